reg_trace_streamer: RTL and testbench
=====================================

Name: reg_trace_streamer

Overview:
- Hardware trace transmitter for the single-cycle RISC-V CPU.
- On each commit trigger it snapshots the PC, then streams one frame (PC followed by x0..x31) over a valid/ready word interface to an off-chip or bench sink.
- Holds the CPU stalled while a frame is streaming.
- Sits beside CPU; reads the register file through a dedicated combinational read port.

Parameters:
MAX_FRAMES, 30, frames sent before done_o asserts; later triggers are ignored
NUM_REGS, 32, registers per frame (x0..x31)
CNT_W, 8, width of frame_cnt_o and drop_cnt_o

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-low
start_i  input  1  trace enable; triggers ignored while low
trigger_i  input  1  one-cycle commit pulse from CPU
pc_i  input  32  PC of the committed instruction, valid with trigger_i
reg_addr_o  output  5  register-file debug read address
reg_data_i  input  32  combinational read data for reg_addr_o
stall_o  output  1  CPU hold request (PC and register writes frozen)
tdata_o  output  32  stream word
tvalid_o  output  1  stream word valid
tready_i  input  1  sink ready
tlast_o  output  1  high on final word of frame (x31)
tindex_o  output  6  word index in frame: 0 = PC, 1..32 = x0..x31
frame_cnt_o  output  CNT_W  completed frames
drop_cnt_o  output  CNT_W  rejected triggers, saturating
done_o  output  1  MAX_FRAMES frames completed

Behaviour:
- Reset (rst_i low, async): state IDLE; tvalid_o, tlast_o, stall_o, done_o = 0; tindex_o, reg_addr_o = 0; tdata_o = 0; frame_cnt_o, drop_cnt_o = 0; PC snapshot register = 0.
- States: IDLE, SEND_PC, SEND_REG, DONE.
- IDLE:
  - trigger_i && start_i at a rising edge: latch pc_i, go to SEND_PC.
  - tvalid_o rises the cycle after the trigger edge (latency 1 cycle).
- SEND_PC: tdata_o = latched PC, tindex_o = 0. On tvalid_o && tready_i, go to SEND_REG with index 1.
- SEND_REG:
  - reg_addr_o = tindex_o - 1; tdata_o = reg_data_i.
  - Each handshake increments the index.
  - Handshake at index 32 (tlast_o = 1): increment frame_cnt_o. If the new count equals MAX_FRAMES, go to DONE; otherwise go to IDLE.
- stall_o = 1 in SEND_PC and SEND_REG, 0 in IDLE and DONE.
  - The CPU is frozen from the cycle after trigger acceptance through the last handshake cycle, so register contents are frame-consistent.
- Stream rules:
  - Once tvalid_o is high, tdata_o, tindex_o and tlast_o stay stable until the handshake.
  - tvalid_o stays high until the handshake; no bubbles inserted by the block.
  - tdata_o = 0 whenever tvalid_o = 0.
- Throughput: with tready_i held high, a frame is exactly 33 cycles of tvalid_o. The next trigger is acceptable at the edge after the last handshake.
- Dropped triggers:
  - trigger_i && start_i while in SEND_PC/SEND_REG (including the last-handshake cycle) is not accepted and increments drop_cnt_o.
  - drop_cnt_o saturates at all-ones.
- start_i low: triggers are ignored and not counted. Deasserting start_i mid-frame does not abort the frame.
- DONE: done_o = 1 and stays set; triggers ignored and not counted; stall_o = 0; exits only by reset.
- x0 streams whatever reg_data_i returns for address 0 (0 in a correct register file); no masking.
- Reset mid-frame: immediate return to reset values; the partial frame is abandoned; no tlast_o is emitted.

Test Plan:
- tready_i = 1, start_i = 1; trigger with pc_i = 0x0000_0004 and x5 = 7 → words 0x4, 0, ..., 7 at tindex 6, ..., tlast_o at tindex 32; stall_o high for 33 cycles; frame_cnt_o = 1.
- tready_i toggling 1/0 each cycle → each word held stable across stalls; frame takes 65 cycles; word order unchanged.
- Second trigger 5 cycles after the first, while busy → drop_cnt_o = 1; only one frame emitted; trigger accepted in the first IDLE cycle starts frame 2.
- 30 back-to-back triggered frames (MAX_FRAMES = 30) → done_o = 1 after the 30th tlast_o handshake; a 31st trigger gives no tvalid_o and drop_cnt_o unchanged.
- rst_i pulled low at tindex 10 → tvalid_o, stall_o, tindex_o = 0 asynchronously; after release, a new trigger starts at tindex 0 with the newly latched PC.
- start_i = 0 with trigger_i pulsed → no frame, drop_cnt_o = 0, stall_o = 0.

Source files
------------

// File: rtl/reg_trace_streamer.sv
// Register-file trace streamer: on a commit trigger, sends PC then x0..x31
// over a valid/ready word stream while holding the CPU stalled.
module reg_trace_streamer #(
  parameter int MAX_FRAMES = 30,
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             trigger_i,
  input  logic [31:0]      pc_i,
  output logic [4:0]       reg_addr_o,
  input  logic [31:0]      reg_data_i,
  output logic             stall_o,
  output logic [31:0]      tdata_o,
  output logic             tvalid_o,
  input  logic             tready_i,
  output logic             tlast_o,
  output logic [5:0]       tindex_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_PC,
    SEND_REG,
    DONE
  } state_t;

  localparam logic [5:0]       LAST_IDX = 6'(NUM_REGS);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_FRAMES);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [5:0]       idx_q, idx_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] fcnt_inc;
  logic             req;
  logic             busy;
  logic             last;

  assign req      = trigger_i & start_i;
  assign busy     = (state_q == SEND_PC) || (state_q == SEND_REG);
  assign last     = (state_q == SEND_REG) && (idx_q == LAST_IDX);
  assign fcnt_inc = fcnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          pc_d    = pc_i;
          idx_d   = '0;
          state_d = SEND_PC;
        end
      end
      SEND_PC: begin
        if (tready_i) begin
          idx_d   = 6'd1;
          state_d = SEND_REG;
        end
      end
      SEND_REG: begin
        if (tready_i) begin
          if (last) begin
            fcnt_d  = fcnt_inc;
            idx_d   = '0;
            state_d = (fcnt_inc == MAX_CNT) ? DONE : IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy triggers are rejected, including on the final handshake
    if (busy && req && (dcnt_q != '1)) begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign tvalid_o    = busy;
  assign stall_o     = busy;
  assign done_o      = (state_q == DONE);
  assign tindex_o    = idx_q;
  assign tlast_o     = last;
  assign frame_cnt_o = fcnt_q;
  assign drop_cnt_o  = dcnt_q;

  always_comb begin
    reg_addr_o = '0;
    tdata_o    = '0;
    unique case (1'b1)
      (state_q == SEND_PC): begin
        tdata_o = pc_q;
      end
      (state_q == SEND_REG): begin
        reg_addr_o = 5'(idx_q - 6'd1);
        tdata_o    = reg_data_i;
      end
      default: begin
        tdata_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_trace_streamer.sv
// Scoreboard bench for reg_trace_streamer: model pushes expected frame words,
// a negedge monitor pops them on each handshake.
module tb_reg_trace_streamer;

  localparam int MAXF = 30;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        trigger_i;
  logic [31:0] pc_i;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic        stall_o;
  logic [31:0] tdata_o;
  logic        tvalid_o;
  logic        tready_i;
  logic        tlast_o;
  logic [5:0]  tindex_o;
  logic [7:0]  frame_cnt_o;
  logic [7:0]  drop_cnt_o;
  logic        done_o;

  logic [31:0] regs [32];
  assign reg_data_i = regs[reg_addr_o];

  reg_trace_streamer #(
    .MAX_FRAMES(MAXF),
    .NUM_REGS  (32),
    .CNT_W     (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .trigger_i  (trigger_i),
    .pc_i       (pc_i),
    .reg_addr_o (reg_addr_o),
    .reg_data_i (reg_data_i),
    .stall_o    (stall_o),
    .tdata_o    (tdata_o),
    .tvalid_o   (tvalid_o),
    .tready_i   (tready_i),
    .tlast_o    (tlast_o),
    .tindex_o   (tindex_o),
    .frame_cnt_o(frame_cnt_o),
    .drop_cnt_o (drop_cnt_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  i;
    logic        l;
  } word_t;

  word_t q[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_rem  = 0;
  int          m_fcnt = 0;
  int          m_dcnt = 0;
  bit          m_done = 1'b0;
  bit          rand_regs = 1'b0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endfunction

  task automatic model_edge();
    bit busy;
    busy = (m_rem > 0);
    if (busy && tready_i) begin
      m_rem--;
      if (m_rem == 0) begin
        m_fcnt++;
        if (m_fcnt == MAXF) m_done = 1'b1;
      end
    end
    if (trigger_i && start_i && !m_done) begin
      if (busy) begin
        if (m_dcnt != 255) m_dcnt++;
      end else if (m_rem == 0) begin
        q.push_back('{pc_i, 6'd0, 1'b0});
        for (int r = 0; r < 32; r++)
          q.push_back('{regs[r], 6'(r + 1), (r == 31)});
        m_rem = 33;
      end
    end
  endtask

  task automatic tick(input logic trg, input logic rdy, input logic [31:0] pc);
    trigger_i = trg;
    tready_i  = rdy;
    pc_i      = pc;
    if (rand_regs && m_rem == 0)
      regs[$urandom_range(31)] = $urandom;
    @(posedge clk_i);
    if (rst_i) model_edge();
    #1;
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      word_t w;
      chk("tvalid", 32'(tvalid_o), 32'(m_rem > 0));
      chk("stall", 32'(stall_o), 32'(m_rem > 0));
      chk("done", 32'(done_o), 32'(m_done));
      chk("frame_cnt", 32'(frame_cnt_o), 32'(m_fcnt));
      chk("drop_cnt", 32'(drop_cnt_o), 32'(m_dcnt));
      if (!tvalid_o) chk("tdata_idle", tdata_o, 32'd0);
      if (tvalid_o && tready_i) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 32'(tindex_o), 32'hFFFF_FFFF);
        end else begin
          w = q.pop_front();
          chk("tdata", tdata_o, w.d);
          chk("tindex", 32'(tindex_o), 32'(w.i));
          chk("tlast", 32'(tlast_o), 32'(w.l));
        end
      end
    end
  end

  initial begin
    rst_i     = 1'b0;
    start_i   = 1'b0;
    trigger_i = 1'b0;
    tready_i  = 1'b1;
    pc_i      = '0;
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;
    regs[5] = 32'd7;
    #1;
    chk("rst_tvalid", 32'(tvalid_o), 32'd0);
    chk("rst_tdata", tdata_o, 32'd0);
    chk("rst_tindex", 32'(tindex_o), 32'd0);
    chk("rst_addr", 32'(reg_addr_o), 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    start_i = 1'b1;

    // directed frame, sink always ready
    tick(1'b1, 1'b1, 32'h0000_0004);
    repeat (40) tick(1'b0, 1'b1, 32'd0);

    // toggling ready plus a trigger while busy
    for (int r = 0; r < 32; r++) regs[r] = 32'h1000 + r;
    tick(1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 80 && m_rem > 0; i++)
      tick(i == 4, (i % 2) == 1, 32'hDEAD_0000);
    tick(1'b1, 1'b1, 32'h0000_0200);
    repeat (40) tick(1'b0, 1'b1, 32'd0);

    // start low: trigger ignored
    start_i = 1'b0;
    tick(1'b1, 1'b1, 32'h0000_0300);
    repeat (5) tick(1'b0, 1'b1, 32'd0);
    start_i = 1'b1;

    // reset mid-frame at tindex 10
    tick(1'b1, 1'b1, 32'h0000_0400);
    for (int k = 0; k < 100 && m_rem != 23; k++)
      tick(1'b0, 1'b1, 32'd0);
    chk("pre_rst_tindex", 32'(tindex_o), 32'd10);
    rst_i = 1'b0;
    #1;
    chk("arst_tvalid", 32'(tvalid_o), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_tindex", 32'(tindex_o), 32'd0);
    chk("arst_fcnt", 32'(frame_cnt_o), 32'd0);
    q.delete();
    m_rem  = 0;
    m_fcnt = 0;
    m_dcnt = 0;
    m_done = 1'b0;
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    tick(1'b1, 1'b1, 32'h0000_0ABC);
    repeat (40) tick(1'b0, 1'b1, 32'd0);

    // random traffic until MAX_FRAMES reached
    rand_regs = 1'b1;
    for (int k = 0; k < 20000 && !m_done; k++) begin
      start_i = ($urandom_range(7) != 0);
      tick($urandom_range(5) == 0, $urandom_range(3) != 0, $urandom);
    end
    chk("reached_done", 32'(m_done), 32'd1);
    start_i = 1'b1;
    for (int k = 0; k < 50; k++)
      tick((k % 3) == 0, 1'b1, $urandom);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
